memo_cache: RTL and testbench

- Second-generation memoization unit: a runtime-fillable, parametrised table keyed by (start_pc, ctx_hash).
- Hash width is generalised over NUM_CTX live-register samples.
- Lookup is registered, with valid/ready handshakes on request and response.
- Entries are loaded at runtime by a tracer/loader fill port, with valid bits, flush and round-robin replacement. Saturating hit/miss counters are exported to CSRs.
- Sits between decode (region-start detection) and regfile/PC redirect.

---
 rtl/memo_cache.sv | 180 ++++++++++++++++++
 tb/tb_memo_cache.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memo_cache.sv
// Memoization table keyed by (start_pc, ctx_hash): registered lookup with valid/ready
// handshakes, runtime fill with round-robin replacement, flush and saturating hit/miss stats.
module memo_cache #(
  parameter int NUM_ENTRIES = 16,
  parameter int MAX_WRITES  = 3,
  parameter int NUM_CTX     = 3,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memo_enable,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_start_pc,
  input  logic [NUM_CTX*32-1:0]    req_ctx,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [31:0]              resp_next_pc,
  output logic [MAX_WRITES-1:0]    resp_wr_mask,
  output logic [MAX_WRITES*5-1:0]  resp_wr_ids,
  output logic [MAX_WRITES*32-1:0] resp_wr_vals,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  logic [31:0]              fill_start_pc,
  input  logic [31:0]              fill_ctx_hash,
  input  logic [31:0]              fill_next_pc,
  input  logic [MAX_WRITES-1:0]    fill_wr_mask,
  input  logic [MAX_WRITES*5-1:0]  fill_wr_ids,
  input  logic [MAX_WRITES*32-1:0] fill_wr_vals,
  input  logic                     flush,
  input  logic                     stats_clr,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  function automatic logic [31:0] rotl32(input logic [31:0] w, input int s);
    logic [63:0] dbl;
    dbl = {w, w} << (s % 32);
    return dbl[63:32];
  endfunction

  // Must stay bit-identical to the tracer's hash, or fills never match lookups.
  function automatic logic [31:0] ctx_hash_f(input logic [NUM_CTX*32-1:0] ctx);
    logic [31:0] h;
    h = '0;
    for (int i = 0; i < NUM_CTX; i++) h = h ^ rotl32(ctx[32*i +: 32], i);
    return h;
  endfunction

  logic [NUM_ENTRIES-1:0]    valid_q;
  logic [IDX_W-1:0]          victim_q, victim_d;
  logic [31:0]               key_pc_q   [NUM_ENTRIES];
  logic [31:0]               key_hash_q [NUM_ENTRIES];
  logic [31:0]               next_pc_q  [NUM_ENTRIES];
  logic [MAX_WRITES-1:0]     mask_q     [NUM_ENTRIES];
  logic [MAX_WRITES*5-1:0]   ids_q      [NUM_ENTRIES];
  logic [MAX_WRITES*32-1:0]  vals_q     [NUM_ENTRIES];

  logic                      resp_valid_q, resp_hit_q;
  logic [31:0]               resp_next_pc_q;
  logic [MAX_WRITES-1:0]     resp_wr_mask_q;
  logic [MAX_WRITES*5-1:0]   resp_wr_ids_q;
  logic [MAX_WRITES*32-1:0]  resp_wr_vals_q;
  logic [CNT_W-1:0]          hit_count_q, miss_count_q;

  logic [31:0]               req_hash;
  logic [NUM_ENTRIES-1:0]    req_match, fill_match;
  logic [IDX_W-1:0]          hit_idx, fill_idx;
  logic                      lookup_hit, serve_hit, req_fire, fill_fire, fill_use_victim;

  assign req_hash = ctx_hash_f(req_ctx);

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign req_match[gi]  = valid_q[gi] && (key_pc_q[gi] == req_start_pc)
                              && (key_hash_q[gi] == req_hash);
      assign fill_match[gi] = valid_q[gi] && (key_pc_q[gi] == fill_start_pc)
                              && (key_hash_q[gi] == fill_ctx_hash);
    end
  endgenerate

  always_comb begin
    hit_idx = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (req_match[k]) hit_idx = IDX_W'(k);
    end
  end

  assign lookup_hit = |req_match;
  assign serve_hit  = memo_enable && lookup_hit;
  assign req_ready  = !resp_valid_q || resp_ready;
  assign req_fire   = req_valid && req_ready;
  assign fill_ready = !flush;
  assign fill_fire  = fill_valid && !flush;

  // Slot priority: same key in place, then first free slot, then round-robin victim.
  always_comb begin
    fill_idx        = victim_q;
    fill_use_victim = 1'b1;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        fill_idx        = IDX_W'(k);
        fill_use_victim = 1'b0;
      end
    end
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (fill_match[k]) begin
        fill_idx        = IDX_W'(k);
        fill_use_victim = 1'b0;
      end
    end
    victim_d = victim_q;
    if (fill_fire && fill_use_victim) victim_d = victim_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (fill_fire) begin
      key_pc_q[fill_idx]   <= fill_start_pc;
      key_hash_q[fill_idx] <= fill_ctx_hash;
      next_pc_q[fill_idx]  <= fill_next_pc;
      mask_q[fill_idx]     <= fill_wr_mask;
      ids_q[fill_idx]      <= fill_wr_ids;
      vals_q[fill_idx]     <= fill_wr_vals;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else begin
      victim_q <= victim_d;
      if (flush)          valid_q           <= '0;
      else if (fill_fire) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_next_pc_q <= '0;
      resp_wr_mask_q <= '0;
      resp_wr_ids_q  <= '0;
      resp_wr_vals_q <= '0;
    end else if (req_fire) begin
      resp_valid_q   <= 1'b1;
      resp_hit_q     <= serve_hit;
      resp_next_pc_q <= serve_hit ? next_pc_q[hit_idx] : '0;
      resp_wr_mask_q <= serve_hit ? mask_q[hit_idx]    : '0;
      resp_wr_ids_q  <= serve_hit ? ids_q[hit_idx]     : '0;
      resp_wr_vals_q <= serve_hit ? vals_q[hit_idx]    : '0;
    end else if (resp_ready) begin
      resp_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (req_fire && memo_enable) begin
      if (lookup_hit && hit_count_q != '1)   hit_count_q  <= hit_count_q + CNT_W'(1);
      if (!lookup_hit && miss_count_q != '1) miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_next_pc = resp_next_pc_q;
  assign resp_wr_mask = resp_wr_mask_q;
  assign resp_wr_ids  = resp_wr_ids_q;
  assign resp_wr_vals = resp_wr_vals_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_memo_cache.sv
// Bench for memo_cache: directed vector table, hand-written corner sequences and a
// randomized run, all checked every cycle against a behavioural table model.
module tb_memo_cache;
  localparam int N = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, memo_enable, req_valid, req_ready, resp_valid, resp_ready, resp_hit;
  logic [31:0] req_start_pc, resp_next_pc;
  logic [95:0] req_ctx, resp_wr_vals, fill_wr_vals;
  logic [2:0]  resp_wr_mask, fill_wr_mask;
  logic [14:0] resp_wr_ids, fill_wr_ids;
  logic fill_valid, fill_ready, flush, stats_clr;
  logic [31:0] fill_start_pc, fill_ctx_hash, fill_next_pc;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  memo_cache #(.NUM_ENTRIES(N), .MAX_WRITES(3), .NUM_CTX(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .memo_enable(memo_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_start_pc(req_start_pc), .req_ctx(req_ctx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_next_pc(resp_next_pc), .resp_wr_mask(resp_wr_mask), .resp_wr_ids(resp_wr_ids),
    .resp_wr_vals(resp_wr_vals), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_start_pc(fill_start_pc), .fill_ctx_hash(fill_ctx_hash), .fill_next_pc(fill_next_pc),
    .fill_wr_mask(fill_wr_mask), .fill_wr_ids(fill_wr_ids), .fill_wr_vals(fill_wr_vals),
    .flush(flush), .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference table: a plain list of entries plus a round-robin victim index.
  logic        m_valid [N];
  logic [31:0] m_pc [N], m_hash [N], m_next [N];
  logic [2:0]  m_mask [N];
  logic [14:0] m_ids [N];
  logic [95:0] m_vals [N];
  int          m_victim, m_hits, m_misses;
  logic        e_rv, e_hit;
  logic [31:0] e_next;
  logic [2:0]  e_mask;
  logic [14:0] e_ids;
  logic [95:0] e_vals;

  function automatic logic [31:0] ref_hash(input logic [95:0] ctx);
    logic [31:0] h, w;
    h = 32'h0;
    for (int i = 0; i < 3; i++) begin
      w = ctx[32*i +: 32];
      h = h ^ ((i == 0) ? w : ((w << i) | (w >> (32 - i))));
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    m_victim = 0; m_hits = 0; m_misses = 0;
    e_rv = 0; e_hit = 0; e_next = 0; e_mask = 0; e_ids = 0; e_vals = 0;
  endtask

  // One clock: check handshakes, advance the model on the current inputs, check outputs.
  task automatic cycle();
    logic acc;
    int hi, slot;
    #1;
    if (rst) begin
      check("req_ready", req_ready, !e_rv || resp_ready);
      check("fill_ready", fill_ready, !flush);
    end
    if (!rst) model_reset();
    else begin
      acc = req_valid && (!e_rv || resp_ready);
      hi = -1;
      for (int k = 0; k < N; k++)
        if (hi < 0 && m_valid[k] && m_pc[k] == req_start_pc && m_hash[k] == ref_hash(req_ctx)) hi = k;
      if (acc) begin
        e_rv = 1;
        e_hit = memo_enable && hi >= 0;
        e_next = e_hit ? m_next[hi] : 32'h0;
        e_mask = e_hit ? m_mask[hi] : 3'h0;
        e_ids  = e_hit ? m_ids[hi]  : 15'h0;
        e_vals = e_hit ? m_vals[hi] : 96'h0;
      end else if (resp_ready) e_rv = 0;
      if (stats_clr) begin m_hits = 0; m_misses = 0; end
      else if (acc && memo_enable) begin
        if (hi >= 0) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
        else m_misses = (m_misses < 15) ? m_misses + 1 : 15;
      end
      if (flush) for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      else if (fill_valid) begin
        slot = -1;
        for (int k = 0; k < N; k++)
          if (slot < 0 && m_valid[k] && m_pc[k] == fill_start_pc && m_hash[k] == fill_ctx_hash) slot = k;
        for (int k = 0; k < N; k++) if (slot < 0 && !m_valid[k]) slot = k;
        if (slot < 0) begin slot = m_victim; m_victim = (m_victim + 1) % N; end
        m_valid[slot] = 1'b1; m_pc[slot] = fill_start_pc; m_hash[slot] = fill_ctx_hash;
        m_next[slot] = fill_next_pc; m_mask[slot] = fill_wr_mask;
        m_ids[slot] = fill_wr_ids; m_vals[slot] = fill_wr_vals;
      end
    end
    @(posedge clk); #1;
    check("resp_valid", resp_valid, e_rv);
    check("resp_hit", resp_hit, e_hit);
    check("resp_next_pc", resp_next_pc, e_next);
    check("resp_wr_mask", resp_wr_mask, e_mask);
    check("resp_wr_ids", resp_wr_ids, e_ids);
    check("resp_wr_vals", resp_wr_vals, e_vals);
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  task automatic idle();
    req_valid = 0; fill_valid = 0; flush = 0; stats_clr = 0; resp_ready = 1; memo_enable = 1;
  endtask

  task automatic drive_lookup(input logic [31:0] pc, input logic [95:0] ctx, input logic en);
    req_valid = 1; req_start_pc = pc; req_ctx = ctx; memo_enable = en;
  endtask

  task automatic drive_fill(input logic [31:0] pc, input logic [31:0] h, input logic [31:0] nxt,
                            input logic [2:0] mask, input logic [14:0] ids, input logic [95:0] vals);
    fill_valid = 1; fill_start_pc = pc; fill_ctx_hash = h; fill_next_pc = nxt;
    fill_wr_mask = mask; fill_wr_ids = ids; fill_wr_vals = vals;
  endtask

  task automatic lookup_key(input int k);
    idle(); drive_lookup(32'h4000 + 32'(4 * k), {64'h0, 32'h100 + 32'(k)}, 1'b1); cycle();
  endtask

  typedef struct {
    bit          is_fill;
    logic [31:0] pc;
    logic [95:0] ctx;
    logic [31:0] hash;
    logic        en;
    logic [31:0] nxt;
    logic [2:0]  mask;
    logic [14:0] ids;
    logic [95:0] vals;
    logic        exp_hit;
    logic [31:0] exp_next;
    logic [3:0]  exp_hc;
    logic [3:0]  exp_mc;
  } vec_t;

  vec_t vecs [6];
  logic [95:0] ctx_a, ctx_b, pool_ctx [6];
  logic [31:0] pool_pc [3];
  int pj;

  initial begin
    ctx_a = {32'h0, 32'h5, 32'h2000};
    ctx_b = {32'h0, 32'h0, 32'h77};
    vecs[0] = '{0, 32'h1000, ctx_a, 32'h0, 1'b1, 32'h0, 3'b000, 15'd0, 96'd0, 1'b0, 32'h0, 4'd0, 4'd1};
    vecs[1] = '{1, 32'h1000, 96'h0, 32'h200A, 1'b1, 32'h2000, 3'b001, 15'd10, 96'd12, 1'b0, 32'h0, 4'd0, 4'd1};
    vecs[2] = '{0, 32'h1000, ctx_a, 32'h0, 1'b1, 32'h0, 3'b000, 15'd0, 96'd0, 1'b1, 32'h2000, 4'd1, 4'd1};
    vecs[3] = '{0, 32'h1000, ctx_a, 32'h0, 1'b0, 32'h0, 3'b000, 15'd0, 96'd0, 1'b0, 32'h0, 4'd1, 4'd1};
    vecs[4] = '{0, 32'h1000, {32'h0, 32'h5, 32'h2001}, 32'h0, 1'b1, 32'h0, 3'b000, 15'd0, 96'd0, 1'b0, 32'h0, 4'd1, 4'd2};
    vecs[5] = '{0, 32'h1004, ctx_a, 32'h0, 1'b1, 32'h0, 3'b000, 15'd0, 96'd0, 1'b0, 32'h0, 4'd1, 4'd3};

    req_start_pc = 0; req_ctx = 0;
    drive_fill(0, 0, 0, 0, 0, 0);
    idle();
    rst = 0;
    model_reset();
    cycle(); cycle();
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_hit_count", hit_count, 4'd0);
    rst = 1;

    for (int i = 0; i < 6; i++) begin
      idle();
      if (vecs[i].is_fill) drive_fill(vecs[i].pc, vecs[i].hash, vecs[i].nxt, vecs[i].mask, vecs[i].ids, vecs[i].vals);
      else drive_lookup(vecs[i].pc, vecs[i].ctx, vecs[i].en);
      cycle();
      if (!vecs[i].is_fill) begin
        check("vec_hit", resp_hit, vecs[i].exp_hit);
        check("vec_next_pc", resp_next_pc, vecs[i].exp_next);
        check("vec_hit_count", hit_count, vecs[i].exp_hc);
        check("vec_miss_count", miss_count, vecs[i].exp_mc);
      end
      $display("vec %0d fill=%0d pc=%h hit=%0d next=%h hits=%0d misses=%0d",
               i, vecs[i].is_fill, vecs[i].pc, resp_hit, resp_next_pc, hit_count, miss_count);
    end

    // Fill and lookup of one key in the same cycle: lookup sees the old table.
    idle(); drive_lookup(32'h3000, ctx_b, 1); drive_fill(32'h3000, 32'h77, 32'h3333, 3'b011, 15'h1234, 96'hABCD);
    cycle(); check("same_cycle_fill_miss", resp_hit, 1'b0);
    idle(); drive_lookup(32'h3000, ctx_b, 1); cycle();
    check("next_cycle_hit", resp_hit, 1'b1);

    // Backpressure for three cycles, then back-to-back acceptance.
    for (int i = 0; i < 3; i++) begin
      idle(); drive_lookup(32'h1000, ctx_a, 1); resp_ready = 0; cycle();
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_resp_valid", resp_valid, 1'b1);
      check("stall_next_pc", resp_next_pc, 32'h3333);
    end
    idle(); drive_lookup(32'h1000, ctx_a, 1); cycle();
    check("resume_next_pc", resp_next_pc, 32'h2000);
    idle(); drive_lookup(32'h3000, ctx_b, 1); cycle();
    check("b2b_valid", resp_valid, 1'b1);
    check("b2b_next_pc", resp_next_pc, 32'h3333);

    // Flush cycle: fill refused, lookup still sees pre-flush table.
    idle(); drive_lookup(32'h1000, ctx_a, 1); flush = 1; drive_fill(32'h5000, 32'h1, 32'h1, 3'b1, 15'h1, 96'h1);
    cycle();
    check("flush_fill_ready", fill_ready, 1'b0);
    check("flush_cycle_hit", resp_hit, 1'b1);
    idle(); drive_lookup(32'h1000, ctx_a, 1); cycle();
    check("post_flush_miss", resp_hit, 1'b0);

    // Fill all slots plus one: slot 0 is replaced, victim moves to 1.
    for (int k = 0; k <= 16; k++) begin
      idle(); drive_fill(32'h4000 + 32'(4 * k), 32'h100 + 32'(k), 32'h8000 + 32'(k), 3'b111,
                         15'(k * 33), {$urandom, $urandom, $urandom});
      cycle();
    end
    lookup_key(0);  check("evicted_key0", resp_hit, 1'b0);
    lookup_key(16); check("key16_next_pc", resp_next_pc, 32'h8010);
    idle(); drive_fill(32'h4014, 32'h105, 32'h9999, 3'b010, 15'h5, 96'h55); cycle();
    idle(); drive_fill(32'h4044, 32'h111, 32'h8011, 3'b100, 15'h7, 96'h77); cycle();
    lookup_key(1);  check("evicted_key1", resp_hit, 1'b0);
    lookup_key(5);  check("refill_key5", resp_next_pc, 32'h9999);
    lookup_key(17); check("key17_next_pc", resp_next_pc, 32'h8011);
    lookup_key(2);  check("key2_kept", resp_next_pc, 32'h8002);

    // Counter saturation and clear-over-increment.
    for (int i = 0; i < 17; i++) lookup_key(5);
    check("hit_saturated", hit_count, 4'hF);
    idle(); drive_lookup(32'h4014, {64'h0, 32'h105}, 1); stats_clr = 1; cycle();
    check("clr_hit_count", hit_count, 4'h0);
    check("clr_miss_count", miss_count, 4'h0);
    check("clr_resp_hit", resp_hit, 1'b1);

    // Reset with a response pending drops it and invalidates the table.
    idle(); cycle();
    idle(); drive_lookup(32'h4014, {64'h0, 32'h105}, 1); resp_ready = 0; cycle();
    idle(); resp_ready = 0; rst = 0; cycle();
    check("reset_drops_resp", resp_valid, 1'b0);
    rst = 1;
    lookup_key(5); check("reset_clears_valid", resp_hit, 1'b0);

    for (int j = 0; j < 6; j++) pool_ctx[j] = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 3; j++) pool_pc[j] = 32'h6000 + 32'(j * 8);
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom % 4) != 0;
      req_start_pc = pool_pc[$urandom % 3];
      req_ctx = pool_ctx[$urandom % 6];
      memo_enable = ($urandom % 8) != 0;
      resp_ready = ($urandom % 4) != 0;
      pj = int'($urandom % 6);
      fill_valid = ($urandom % 3) == 0;
      fill_start_pc = pool_pc[$urandom % 3];
      fill_ctx_hash = ref_hash(pool_ctx[pj]);
      fill_next_pc = $urandom;
      fill_wr_mask = 3'($urandom);
      fill_wr_ids = 15'($urandom);
      fill_wr_vals = {$urandom, $urandom, $urandom};
      flush = ($urandom % 40) == 0;
      stats_clr = ($urandom % 50) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
